ch2_rr_arbiter8: RTL and testbench
==================================

CH2_RR_ARBITER8 -- requirements
Module: ch2_rr_arbiter8

Interface
- REQ-001 SHALL have parameter: HOLD_MAX, default 15, maximum cycles a grant is held before forced release (legal 1..15).
- REQ-002 SHALL have port: CLK  input  1  the only clock; all state changes on its rising edge.
- REQ-003 SHALL have port: RST_N  input  1  reset, synchronous and active-low.
- REQ-004 SHALL have port: REQ  input  8  request lines; bit i set means requester i wants the shared resource.
- REQ-005 SHALL have port: DONE  input  1  the granted requester's release strobe; ignored outside GRANT.
- REQ-006 SHALL have port: GNT  output  8  one-hot grant, or all zero.
- REQ-007 SHALL have port: GNT_IDX  output  3  binary index of the granted requester; 0 when none is granted.
- REQ-008 SHALL have port: BUSY  output  1  high while in GRANT.
- REQ-009 SHALL have port: TIMEOUT  output  1  one-cycle pulse on a forced release.

Function
- REQ-010 SHALL implement two states, IDLE and GRANT, plus a 3-bit round-robin pointer PTR and a 4-bit hold counter CNT.
- REQ-011 In IDLE with REQ==0, SHALL stay in IDLE with GNT=0, GNT_IDX=0 and BUSY=0.
- REQ-012 In IDLE with REQ!=0, SHALL select the first set bit searching circularly from PTR upward (PTR, PTR+1, ..., 7, 0, ..., PTR-1).
- REQ-013 On the same edge as REQ-012, SHALL register GNT (one-hot winner), GNT_IDX (winner), BUSY=1 and CNT=0, and enter GRANT.
- REQ-014 Grant latency SHALL be 1 cycle: REQ sampled at edge k gives a valid GNT after edge k.
- REQ-015 In GRANT, SHALL hold GNT/GNT_IDX unchanged and ignore changes on non-granted REQ bits.
- REQ-016 In GRANT, SHALL increment CNT each cycle in which no release occurs.
- REQ-017 SHALL release on DONE=1, or when REQ[GNT_IDX]=0, or when CNT==HOLD_MAX-1; GNT is therefore high for at most HOLD_MAX cycles.
- REQ-018 On release, at the next edge SHALL set GNT=0, GNT_IDX=0, BUSY=0, PTR=GNT_IDX+1 mod 8 (7 wraps to 0), and enter IDLE.
- REQ-019 After a release, SHALL spend at least one IDLE cycle before the next grant.
- REQ-020 TIMEOUT SHALL pulse high for exactly the cycle following a release caused only by the CNT limit.
- REQ-021 When DONE=1 or a REQ drop coincides with the CNT limit, the release SHALL count as normal and TIMEOUT SHALL stay 0.
- REQ-022 GNT SHALL never have more than one bit set; GNT_IDX SHALL always equal the encoded GNT.

Reset
- REQ-023 SHALL, with RST_N=0 at a rising edge, set state=IDLE, GNT=0, GNT_IDX=0, BUSY=0, TIMEOUT=0, PTR=0 and CNT=0.
- REQ-024 RST_N=0 mid-grant SHALL abort the grant at that edge with no TIMEOUT pulse.
- REQ-025 Reset SHALL take priority over all other inputs.

Structure
- REQ-026 Shared package ch2_arb_pkg SHALL hold N_REQ=8, IDX_W=3, CNT_W=4 and the state enumeration (IDLE, GRANT).
- REQ-027 SHALL use one sub-module, ch2_prio_enc83 (combinational 8-to-3 priority encoder with a valid output), to encode the rotated request vector; the winner is the encoder output plus PTR, mod 8.

Verification
- REQ-028 Reset, then REQ=8'b00000001 -> one cycle later GNT=8'b00000001, GNT_IDX=0, BUSY=1.
- REQ-029 REQ=8'hFF held, DONE pulsed once per grant -> grant order 0,1,2,...,7,0, with one idle cycle between grants.
- REQ-030 After granting requester 5 (PTR=6), REQ=8'b00100001 -> GNT_IDX=0 (wrap past 6, 7).
- REQ-031 REQ=8'b00001000 held, DONE=0, HOLD_MAX=15 -> GNT=8'b00001000 for exactly 15 cycles, then GNT=0 and a 1-cycle TIMEOUT; next grant goes to 3 again only after the idle cycle.
- REQ-032 DONE=1 in the same cycle as CNT==HOLD_MAX-1 -> release with TIMEOUT=0.
- REQ-033 RST_N=0 during GRANT with GNT_IDX=4 -> next edge all outputs 0, PTR=0; REQ=8'hFF then grants 0.

Source files
------------

// File: rtl/ch2_arb_pkg.sv
// ----------------------------------------------------------------------------
// ch2_arb_pkg
// Shared constants and types for the 8-way round-robin arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   CNT_W   : width of the grant hold counter
//   state_t : arbiter control states (IDLE, GRANT)
// ----------------------------------------------------------------------------
package ch2_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : ch2_arb_pkg

// File: rtl/ch2_prio_enc83.sv
// ----------------------------------------------------------------------------
// ch2_prio_enc83
// Combinational 8-to-3 priority encoder. Bit 0 has the highest priority.
// Ports:
//   req   [N_REQ-1:0] in  : request vector (already rotated by the caller)
//   idx   [IDX_W-1:0] out : index of the lowest set bit, 0 if none set
//   valid             out : high when at least one bit of req is set
// ----------------------------------------------------------------------------
module ch2_prio_enc83
  import ch2_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule : ch2_prio_enc83

// File: rtl/ch2_rr_arbiter8.sv
// ----------------------------------------------------------------------------
// ch2_rr_arbiter8
// Eight-requester round-robin arbiter with a bounded grant hold time.
// A grant is issued one cycle after a request is seen in IDLE, held until the
// owner strobes DONE, drops its request, or HOLD_MAX cycles elapse. Every
// release is followed by at least one IDLE cycle, and the search pointer moves
// to the requester just after the released owner.
// Parameters:
//   HOLD_MAX : maximum grant length in cycles (1..15)
// Ports:
//   CLK             in  : clock, rising edge
//   RST_N           in  : synchronous active-low reset
//   REQ     [7:0]   in  : request lines
//   DONE            in  : release strobe from the current owner
//   GNT     [7:0]   out : one-hot grant, or zero
//   GNT_IDX [2:0]   out : index of the granted requester, 0 when idle
//   BUSY            out : high while a grant is active
//   TIMEOUT         out : one-cycle pulse after a forced (hold-limit) release
// ----------------------------------------------------------------------------
module ch2_rr_arbiter8
  import ch2_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
)(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [N_REQ-1:0] GNT,
  output logic [IDX_W-1:0] GNT_IDX,
  output logic             BUSY,
  output logic             TIMEOUT
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX - 1);

  state_t            state_q,   state_d;
  logic [N_REQ-1:0]  gnt_q,     gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]  ptr_q,     ptr_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              timeout_q, timeout_d;

  logic [N_REQ-1:0]  req_rot;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_valid;
  logic [IDX_W-1:0]  winner;
  logic              normal_rel;
  logic              limit_hit;

  // Rotate requests so that bit 0 of req_rot is requester PTR; the 3-bit
  // index addition wraps naturally modulo 8.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = REQ[IDX_W'(i) + ptr_q];
    end
  end

  ch2_prio_enc83 u_enc (
    .req   (req_rot),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Undo the rotation to get the absolute winner index.
  assign winner = enc_idx + ptr_q;

  // A DONE strobe or a dropped request is a normal release; it takes
  // precedence over the hold limit so TIMEOUT stays low when both coincide.
  assign normal_rel = DONE || !REQ[gnt_idx_q];
  assign limit_hit  = (cnt_q == CNT_LIMIT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d   = GRANT;
          gnt_d     = N_REQ'(1) << winner;
          gnt_idx_d = winner;
          cnt_d     = '0;
        end
      end
      GRANT: begin
        if (normal_rel || limit_hit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          timeout_d = !normal_rel;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_IDX = gnt_idx_q;
  assign BUSY    = (state_q == GRANT);
  assign TIMEOUT = timeout_q;

endmodule : ch2_rr_arbiter8

// File: tb/tb_ch2_rr_arbiter8.sv
// ----------------------------------------------------------------------------
// tb_ch2_rr_arbiter8
// Self-checking bench for ch2_rr_arbiter8: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model
// that searches requesters circularly and counts how long the grant is held.
// ----------------------------------------------------------------------------
module tb_ch2_rr_arbiter8;

  localparam int HOLD_MAX = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_to;

  ch2_rr_arbiter8 #(.HOLD_MAX(HOLD_MAX)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .REQ     (req),
    .DONE    (done),
    .GNT     (gnt),
    .GNT_IDX (gnt_idx),
    .BUSY    (busy),
    .TIMEOUT (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model one rising edge using the inputs present at that edge.
  function automatic void modelEdge(input bit rn, input logic [7:0] r, input bit d);
    bit voluntary;
    if (!rn) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (r[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      voluntary = d || !r[m_idx];
      if (voluntary || m_held == HOLD_MAX) begin
        m_to   = !voluntary;
        m_ptr  = (m_idx + 1) % 8;
        m_busy = 0;
        m_idx  = 0;
      end else begin
        m_held++;
      end
    end
  endfunction

  // Drive inputs, advance one edge, update the model, then compare all
  // outputs shortly after the edge.
  task automatic applyStimulus(input bit rn, input logic [7:0] r, input bit d);
    logic [7:0] exp_gnt;
    rst_n = rn;
    req   = r;
    done  = d;
    @(posedge clk);
    modelEdge(rn, r, d);
    #1;
    exp_gnt = m_busy ? (8'h01 << m_idx) : 8'h00;
    checkOutput("gnt",     32'(gnt),     32'(exp_gnt));
    checkOutput("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    checkOutput("busy",    32'(busy),    32'(m_busy));
    checkOutput("timeout", 32'(timeout), 32'(m_to));
    checkOutput("onehot",  32'($countones(gnt) <= 1), 32'(1));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int hold_cycles;
    int guard;
    logic [7:0] rreq;
    bit rdone;
    bit rrst;

    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // Reset state.
    doReset();
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("idle_no_req_gnt", 32'(gnt), 32'h0);

    // Single request from requester 0: grant after one cycle.
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkOutput("first_gnt", 32'(gnt), 32'h01);
    checkOutput("first_busy", 32'(busy), 32'h1);
    applyStimulus(1'b1, 8'h01, 1'b1);

    // All requesting, DONE once per grant: order 0..7,0 with idle gaps.
    doReset();
    for (int g = 0; g < 9; g++) begin
      applyStimulus(1'b1, 8'hFF, 1'b0);
      checkOutput("rr_order", 32'(gnt_idx), 32'(g % 8));
      applyStimulus(1'b1, 8'hFF, 1'b1);
      checkOutput("rr_gap_busy", 32'(busy), 32'h0);
    end

    // After granting 5 the search starts at 6 and wraps to 0.
    doReset();
    applyStimulus(1'b1, 8'h20, 1'b0);
    checkOutput("grant5", 32'(gnt_idx), 32'd5);
    applyStimulus(1'b1, 8'h20, 1'b1);
    applyStimulus(1'b1, 8'h21, 1'b0);
    checkOutput("wrap_to_0", 32'(gnt_idx), 32'd0);

    // Hold limit: requester 3 held without DONE.
    doReset();
    hold_cycles = 0;
    guard = 0;
    applyStimulus(1'b1, 8'h08, 1'b0);
    while (gnt == 8'h08 && guard < 40) begin
      hold_cycles++;
      guard++;
      applyStimulus(1'b1, 8'h08, 1'b0);
    end
    checkOutput("hold_len", 32'(hold_cycles), 32'(HOLD_MAX));
    checkOutput("timeout_pulse", 32'(timeout), 32'h1);
    checkOutput("timeout_gnt0", 32'(gnt), 32'h0);
    applyStimulus(1'b1, 8'h08, 1'b0);
    checkOutput("regrant3", 32'(gnt), 32'h08);
    checkOutput("timeout_once", 32'(timeout), 32'h0);

    // DONE coinciding with the last permitted cycle: normal release.
    doReset();
    applyStimulus(1'b1, 8'h08, 1'b0);
    repeat (HOLD_MAX - 1) applyStimulus(1'b1, 8'h08, 1'b0);
    checkOutput("pre_limit_gnt", 32'(gnt), 32'h08);
    applyStimulus(1'b1, 8'h08, 1'b1);
    checkOutput("done_at_limit_to", 32'(timeout), 32'h0);
    checkOutput("done_at_limit_gnt", 32'(gnt), 32'h0);

    // Reset in the middle of a grant to requester 4.
    doReset();
    applyStimulus(1'b1, 8'h10, 1'b0);
    checkOutput("grant4", 32'(gnt_idx), 32'd4);
    applyStimulus(1'b0, 8'hFF, 1'b1);
    checkOutput("midrst_gnt", 32'(gnt), 32'h0);
    checkOutput("midrst_to", 32'(timeout), 32'h0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("post_rst_grant0", 32'(gnt_idx), 32'd0);

    // Randomized traffic against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      rreq  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 2) == 0) rreq = rreq & 8'($urandom);
      // Keep the owner's request high most of the time so limits are reached.
      if (m_busy && $urandom_range(0, 9) != 0) rreq[m_idx] = 1'b1;
      rdone = ($urandom_range(0, 15) == 0);
      rrst  = ($urandom_range(0, 199) != 0);
      applyStimulus(rrst, rreq, rdone);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ch2_rr_arbiter8
